// File: rtl/us_sched_pkg.sv
// Shared types and constants for the three-sensor HC-SR04 scheduler.
// Sensor indices, the FSM state type, default timing and the small index helpers.
package us_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    ARM,
    MEAS,
    GAP
  } state_e;

  localparam int SENS_R   = 0;
  localparam int SENS_M   = 1;
  localparam int SENS_L   = 2;
  localparam int NUM_SENS = 3;
  localparam int DIST_W   = 20;

  localparam int                TRIG_CYCLES_DEF = 500;
  localparam int                ARM_TIMEOUT_DEF = 50000;
  localparam logic [DIST_W-1:0] MAX_ECHO_DEF    = 20'hFFFFF;
  localparam int                GAP_CYCLES_DEF  = 500000;

  // Round-robin successor over the three sensor slots.
  function automatic logic [1:0] sel_inc(input logic [1:0] sel);
    return (sel >= 2'd2) ? 2'd0 : sel + 2'd1;
  endfunction

  function automatic logic [NUM_SENS-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_SENS-1:0] oh;
    oh = '0;
    case (sel)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/us_sensor_scheduler_if.sv
// Pin/result bundle between the scheduler and its surroundings (sensors, motion FSM).
// master = host/sensor side, slave = scheduler.
interface us_sensor_scheduler_if;
  import us_sched_pkg::*;

  logic                enable;
  logic [NUM_SENS-1:0] sens_mask;
  logic [NUM_SENS-1:0] echo;
  logic [NUM_SENS-1:0] trig;
  logic [DIST_W-1:0]   dist_r;
  logic [DIST_W-1:0]   dist_m;
  logic [DIST_W-1:0]   dist_l;
  logic [NUM_SENS-1:0] done;
  logic [NUM_SENS-1:0] timeout;
  logic                busy;
  logic [1:0]          cur_sel;

  modport master (
    output enable, sens_mask, echo,
    input  trig, dist_r, dist_m, dist_l, done, timeout, busy, cur_sel
  );

  modport slave (
    input  enable, sens_mask, echo,
    output trig, dist_r, dist_m, dist_l, done, timeout, busy, cur_sel
  );

endinterface

// File: rtl/us_echo_sync.sv
// Two-flop synchronizer for one raw echo pin, plus rise/fall pulses on the synced level.
module us_echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign lvl_o  = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/us_sensor_scheduler.sv
// Round-robin HC-SR04 sequencer: trigger, time the echo, publish a saturating count per sensor.
// A single shared counter times every state and is cleared whenever the state changes.
module us_sensor_scheduler
  import us_sched_pkg::*;
#(
  parameter int                TRIG_CYCLES = TRIG_CYCLES_DEF,
  parameter int                ARM_TIMEOUT = ARM_TIMEOUT_DEF,
  parameter logic [DIST_W-1:0] MAX_ECHO    = MAX_ECHO_DEF,
  parameter int                GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  us_sensor_scheduler_if.slave  sched_if
);

  localparam logic [DIST_W-1:0] TRIG_LAST = DIST_W'(TRIG_CYCLES - 1);
  localparam logic [DIST_W-1:0] ARM_LAST  = DIST_W'(ARM_TIMEOUT - 1);
  localparam logic [DIST_W-1:0] GAP_LAST  = DIST_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [DIST_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          cur_sel_q, cur_sel_d;
  logic [DIST_W-1:0]   dist_q [NUM_SENS];
  logic [NUM_SENS-1:0] done_q;
  logic [NUM_SENS-1:0] timeout_q;

  logic                rep_en;
  logic [DIST_W-1:0]   rep_val;
  logic                rep_to;

  logic [NUM_SENS-1:0] echo_lvl, echo_rise, echo_fall;
  logic [3:0]          lvl_ext, rise_ext, fall_ext, mask_ext;
  logic [NUM_SENS-1:0] sel_oh;
  logic [1:0]          nxt_sel;

  for (genvar gi = 0; gi < NUM_SENS; gi++) begin : g_sync
    us_echo_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .echo_i (sched_if.echo[gi]),
      .lvl_o  (echo_lvl[gi]),
      .rise_o (echo_rise[gi]),
      .fall_o (echo_fall[gi])
    );
  end

  // Padded to 4 bits so a 2-bit selector can index them without a range hole.
  assign lvl_ext  = {1'b0, echo_lvl};
  assign rise_ext = {1'b0, echo_rise};
  assign fall_ext = {1'b0, echo_fall};
  assign mask_ext = {1'b0, sched_if.sens_mask};
  assign sel_oh   = sel_onehot(cur_sel_q);
  assign nxt_sel  = sel_inc(cur_sel_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_sel_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    rep_en    = 1'b0;
    rep_val   = cnt_q;
    rep_to    = 1'b0;
    case (state_q)
      IDLE: begin
        // Masked slots are stepped over one index per cycle.
        if (sched_if.enable && (|sched_if.sens_mask)) begin
          if (mask_ext[cur_sel_q]) state_d = TRIG;
          else                     cur_sel_d = nxt_sel;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) state_d = ARM;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ARM: begin
        if (rise_ext[cur_sel_q]) begin
          state_d = MEAS;
        end else if (cnt_q == ARM_LAST) begin
          rep_en  = 1'b1;
          rep_val = MAX_ECHO;
          rep_to  = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEAS: begin
        if (fall_ext[cur_sel_q]) begin
          rep_en  = 1'b1;
          state_d = GAP;
        end else if (cnt_q == MAX_ECHO) begin
          rep_en  = 1'b1;
          rep_val = MAX_ECHO;
          rep_to  = 1'b1;
          state_d = GAP;
        end else if (lvl_ext[cur_sel_q]) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        // Counter parks at its last value, so a masked successor costs one extra cycle each.
        if (cnt_q == GAP_LAST) begin
          cur_sel_d = nxt_sel;
          if (!sched_if.enable || (sched_if.sens_mask == '0)) state_d = IDLE;
          else if (mask_ext[nxt_sel])                         state_d = TRIG;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    sched_if.trig = '0;
    if (state_q == TRIG) sched_if.trig = sel_oh;
    sched_if.busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= '0;
      timeout_q <= '0;
      for (int i = 0; i < NUM_SENS; i++) dist_q[i] <= '0;
    end else begin
      done_q <= rep_en ? sel_oh : '0;
      for (int i = 0; i < NUM_SENS; i++) begin
        if (rep_en && sel_oh[i]) begin
          dist_q[i]    <= rep_val;
          timeout_q[i] <= rep_to;
        end
      end
    end
  end

  assign sched_if.dist_r  = dist_q[SENS_R];
  assign sched_if.dist_m  = dist_q[SENS_M];
  assign sched_if.dist_l  = dist_q[SENS_L];
  assign sched_if.done    = done_q;
  assign sched_if.timeout = timeout_q;
  assign sched_if.cur_sel = cur_sel_q;

endmodule

// File: tb/tb_us_sensor_scheduler.sv
// Bench for us_sensor_scheduler: behavioural echo responders per sensor, a report monitor,
// and one task per scenario comparing reports against the expected rotation and echo widths.
module tb_us_sensor_scheduler;
  import us_sched_pkg::*;

  localparam int                TRIG  = 20;
  localparam int                ARMTO = 300;
  localparam int                GAP   = 60;
  localparam logic [DIST_W-1:0] MAXE  = 20'd3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  us_sensor_scheduler_if bus ();

  us_sensor_scheduler #(
    .TRIG_CYCLES (TRIG),
    .ARM_TIMEOUT (ARMTO),
    .MAX_ECHO    (MAXE),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sched_if (bus)
  );

  typedef struct {
    logic [2:0]             done;
    logic [2:0][DIST_W-1:0] d;
    logic [2:0]             to;
    logic [2:0]             echo;
    longint                 cyc;
    longint                 tf;
  } rep_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     mode [3];   // 0 = normal echo, 1 = no echo, 2 = stuck high
  int     dly  [3];
  int     wid  [3];
  rep_t   rep_q [$];
  int     trig_order [$];
  int     trig_w [$];
  int     trig_cnt [3];
  int     hl [3];
  longint tfall [3];
  longint cyc = 0;
  logic [2:0] mtrig = '0;
  logic [2:0] rtrig = '0;
  int     rcnt [3];
  int     hcnt [3];

  // Monitor: trigger pulse widths/order and every done strobe.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int s = 0; s < 3; s++) begin
        if (bus.trig[s]) begin
          if (!mtrig[s]) trig_order.push_back(s);
          hl[s]++;
        end else if (mtrig[s]) begin
          trig_w.push_back(hl[s]);
          trig_cnt[s]++;
          tfall[s] = cyc;
          hl[s] = 0;
        end
      end
      mtrig = bus.trig;
      if (bus.done != 3'b000) begin
        rep_t r;
        r.done = bus.done;
        r.d[0] = bus.dist_r;
        r.d[1] = bus.dist_m;
        r.d[2] = bus.dist_l;
        r.to   = bus.timeout;
        r.echo = bus.echo;
        r.cyc  = cyc;
        r.tf   = bus.done[0] ? tfall[0] : (bus.done[1] ? tfall[1] : tfall[2]);
        rep_q.push_back(r);
      end
    end
  end

  // Sensor model: after a trigger falls, wait dly cycles then hold echo high for wid cycles.
  initial begin
    bus.echo = 3'b000;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        if (mode[s] == 2) begin
          bus.echo[s] = 1'b1;
          rcnt[s] = 0;
          hcnt[s] = 0;
        end else begin
          if (rtrig[s] && !bus.trig[s] && mode[s] == 0) rcnt[s] = dly[s];
          if (rcnt[s] > 0) begin
            rcnt[s]--;
            if (rcnt[s] == 0) hcnt[s] = wid[s];
          end
          if (hcnt[s] > 0) begin
            bus.echo[s] = 1'b1;
            hcnt[s]--;
          end else begin
            bus.echo[s] = 1'b0;
          end
        end
      end
      rtrig = bus.trig;
    end
  end

  // Expected rotation: first enabled slot at/after 0 initially, then the next enabled one mod 3.
  function automatic int next_sens(input int prev, input logic [2:0] m);
    int c;
    if (prev < 0) begin
      for (int k = 0; k < 3; k++) if (m[k]) return k;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        c = (prev + k) % 3;
        if (m[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic randomize_sensors();
    for (int s = 0; s < 3; s++) begin
      mode[s] = 0;
      dly[s]  = $urandom_range(150, 5);
      wid[s]  = $urandom_range(800, 100);
    end
  endtask

  task automatic do_reset();
    bus.enable = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rep_q.delete();
    trig_order.delete();
    trig_w.delete();
    for (int s = 0; s < 3; s++) begin
      trig_cnt[s] = 0;
      hl[s] = 0;
      rcnt[s] = 0;
      hcnt[s] = 0;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_reps(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rep_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (rep_q.size() >= n);
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.trig !== 3'b000) begin n_bad++; $display("FAIL reset_trig: got %b expected 000", bus.trig); end
    n_cmp++; if (bus.done !== 3'b000) begin n_bad++; $display("FAIL reset_done: got %b expected 000", bus.done); end
    n_cmp++; if (bus.timeout !== 3'b000) begin n_bad++; $display("FAIL reset_timeout: got %b expected 000", bus.timeout); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.cur_sel !== 2'd0) begin n_bad++; $display("FAIL reset_cur_sel: got %0d expected 0", bus.cur_sel); end
    n_cmp++;
    if ({bus.dist_r, bus.dist_m, bus.dist_l} !== 60'd0) begin
      n_bad++;
      $display("FAIL reset_dist: got r=%0d m=%0d l=%0d expected 0", bus.dist_r, bus.dist_m, bus.dist_l);
    end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_all_sensors();
    bit ok;
    int exp, prev, diff;
    int ed [3];
    logic [2:0] oh;
    rep_t r;
    do_reset();
    randomize_sensors();
    ed = '{0, 0, 0};
    bus.sens_mask = 3'b111;
    bus.enable = 1'b1;
    wait_reps(6, 12000, ok);
    bus.enable = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL all_wait: got %0d reports expected 6", rep_q.size()); end
    prev = -1;
    for (int i = 0; i < rep_q.size() && i < 6; i++) begin
      r = rep_q[i];
      exp = next_sens(prev, 3'b111);
      oh = 3'b001 << exp;
      n_cmp++; if (r.done !== oh) begin n_bad++; $display("FAIL all_done[%0d]: got %b expected %b", i, r.done, oh); end
      diff = int'(r.d[exp]) - wid[exp];
      n_cmp++; if (diff < -2 || diff > 2) begin n_bad++; $display("FAIL all_dist[%0d]: got %0d expected %0d+/-2", i, r.d[exp], wid[exp]); end
      n_cmp++; if (r.to !== 3'b000) begin n_bad++; $display("FAIL all_timeout[%0d]: got %b expected 000", i, r.to); end
      for (int o = 0; o < 3; o++) begin
        if (o != exp) begin
          diff = int'(r.d[o]) - ed[o];
          n_cmp++; if (diff < -2 || diff > 2) begin n_bad++; $display("FAIL all_hold[%0d] s%0d: got %0d expected %0d", i, o, r.d[o], ed[o]); end
        end
      end
      if (i > 0) begin
        n_cmp++; if (r.cyc - rep_q[i-1].cyc <= 1) begin n_bad++; $display("FAIL all_strobe[%0d]: gap %0d cycles expected >1", i, r.cyc - rep_q[i-1].cyc); end
      end
      ed[exp] = wid[exp];
      $display("all: report %0d sensor %0d dist %0d width %0d", i, exp, r.d[exp], wid[exp]);
      prev = exp;
    end
    for (int i = 0; i < trig_w.size(); i++) begin
      n_cmp++; if (trig_w[i] != TRIG) begin n_bad++; $display("FAIL all_trig_w[%0d]: got %0d expected %0d", i, trig_w[i], TRIG); end
    end
    for (int i = 0; i < trig_order.size() && i < 6; i++) begin
      n_cmp++; if (trig_order[i] != i % 3) begin n_bad++; $display("FAIL all_trig_order[%0d]: got %0d expected %0d", i, trig_order[i], i % 3); end
    end
  endtask

  task automatic test_mask_101();
    bit ok;
    logic [2:0] oh;
    do_reset();
    randomize_sensors();
    bus.sens_mask = 3'b101;
    bus.enable = 1'b1;
    wait_reps(4, 8000, ok);
    bus.enable = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL m101_wait: got %0d reports expected 4", rep_q.size()); end
    for (int i = 0; i < rep_q.size() && i < 4; i++) begin
      oh = (i % 2 == 0) ? 3'b001 : 3'b100;
      n_cmp++; if (rep_q[i].done !== oh) begin n_bad++; $display("FAIL m101_done[%0d]: got %b expected %b", i, rep_q[i].done, oh); end
      $display("m101: report %0d done %b", i, rep_q[i].done);
    end
    n_cmp++; if (trig_cnt[1] != 0) begin n_bad++; $display("FAIL m101_trig_m: got %0d expected 0", trig_cnt[1]); end
    n_cmp++; if (bus.dist_m !== 20'd0) begin n_bad++; $display("FAIL m101_dist_m: got %0d expected 0", bus.dist_m); end
  endtask

  task automatic test_timeout_m();
    bit ok;
    int diff;
    rep_t r;
    do_reset();
    randomize_sensors();
    mode[1] = 1;
    bus.sens_mask = 3'b111;
    bus.enable = 1'b1;
    wait_reps(2, 4000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_wait1: got %0d reports expected 2", rep_q.size()); end
    if (ok) begin
      r = rep_q[1];
      n_cmp++; if (r.done !== 3'b010) begin n_bad++; $display("FAIL to_done: got %b expected 010", r.done); end
      n_cmp++; if (r.d[1] !== MAXE) begin n_bad++; $display("FAIL to_dist: got %0d expected %0d", r.d[1], MAXE); end
      n_cmp++; if (r.to !== 3'b010) begin n_bad++; $display("FAIL to_flag: got %b expected 010", r.to); end
      diff = int'(r.cyc - r.tf);
      n_cmp++; if (diff < ARMTO - 1 || diff > ARMTO + 1) begin n_bad++; $display("FAIL to_latency: got %0d expected %0d", diff, ARMTO); end
      $display("timeout: M reported %0d after %0d cycles", r.d[1], diff);
    end
    mode[1] = 0;
    dly[1]  = 100;
    wid[1]  = 2048;
    wait_reps(5, 8000, ok);
    bus.enable = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_wait2: got %0d reports expected 5", rep_q.size()); end
    if (ok) begin
      r = rep_q[4];
      diff = int'(r.d[1]) - 2048;
      n_cmp++; if (r.done !== 3'b010) begin n_bad++; $display("FAIL to_rec_done: got %b expected 010", r.done); end
      n_cmp++; if (diff < -2 || diff > 2) begin n_bad++; $display("FAIL to_rec_dist: got %0d expected 2048+/-2", r.d[1]); end
      n_cmp++; if (r.to[1] !== 1'b0) begin n_bad++; $display("FAIL to_rec_flag: got %b expected 0", r.to[1]); end
      $display("timeout: M recovered dist %0d", r.d[1]);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    rep_t r;
    do_reset();
    randomize_sensors();
    wid[0] = int'(MAXE) + 500;
    bus.sens_mask = 3'b001;
    bus.enable = 1'b1;
    wait_reps(1, 5000, ok);
    bus.enable = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sat_wait: got %0d reports expected 1", rep_q.size()); end
    if (ok) begin
      r = rep_q[0];
      n_cmp++; if (r.d[0] !== MAXE) begin n_bad++; $display("FAIL sat_dist: got %0d expected %0d", r.d[0], MAXE); end
      n_cmp++; if (r.to !== 3'b001) begin n_bad++; $display("FAIL sat_flag: got %b expected 001", r.to); end
      n_cmp++; if (r.echo[0] !== 1'b1) begin n_bad++; $display("FAIL sat_early: echo at report %b expected 1", r.echo[0]); end
      $display("saturation: R dist %0d timeout %b", r.d[0], r.to);
    end
  endtask

  task automatic test_stuck_l();
    bit ok;
    int diff;
    rep_t r;
    randomize_sensors();
    mode[2] = 2;
    do_reset();
    bus.sens_mask = 3'b111;
    bus.enable = 1'b1;
    wait_reps(4, 6000, ok);
    bus.enable = 1'b0;
    mode[2] = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stuck_wait: got %0d reports expected 4", rep_q.size()); end
    if (ok) begin
      r = rep_q[2];
      diff = int'(r.cyc - r.tf);
      n_cmp++; if (r.done !== 3'b100) begin n_bad++; $display("FAIL stuck_done: got %b expected 100", r.done); end
      n_cmp++; if (r.d[2] !== MAXE) begin n_bad++; $display("FAIL stuck_dist: got %0d expected %0d", r.d[2], MAXE); end
      n_cmp++; if (r.to[2] !== 1'b1) begin n_bad++; $display("FAIL stuck_flag: got %b expected 1", r.to[2]); end
      n_cmp++; if (diff < ARMTO - 1 || diff > ARMTO + 1) begin n_bad++; $display("FAIL stuck_latency: got %0d expected %0d", diff, ARMTO); end
      n_cmp++; if (rep_q[3].done !== 3'b001) begin n_bad++; $display("FAIL stuck_next: got %b expected 001", rep_q[3].done); end
      $display("stuck: L dist %0d then done %b", r.d[2], rep_q[3].done);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int k, diff;
    do_reset();
    randomize_sensors();
    wid[1] = 1000;
    bus.sens_mask = 3'b111;
    bus.enable = 1'b1;
    k = 0;
    while (bus.echo[1] !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
    n_cmp++; if (bus.echo[1] !== 1'b1) begin n_bad++; $display("FAIL drop_wait_echo: got %b expected 1", bus.echo[1]); end
    repeat (100) @(negedge clk);
    bus.enable = 1'b0;
    wait_reps(2, 2000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_wait: got %0d reports expected 2", rep_q.size()); end
    if (ok) begin
      diff = int'(rep_q[1].d[1]) - 1000;
      n_cmp++; if (rep_q[1].done !== 3'b010) begin n_bad++; $display("FAIL drop_done: got %b expected 010", rep_q[1].done); end
      n_cmp++; if (diff < -2 || diff > 2) begin n_bad++; $display("FAIL drop_dist: got %0d expected 1000+/-2", rep_q[1].d[1]); end
      k = 0;
      while (bus.busy === 1'b1 && k < GAP + 50) begin @(negedge clk); k++; end
      diff = int'(cyc - rep_q[1].cyc);
      n_cmp++; if (diff < GAP - 2 || diff > GAP + 2) begin n_bad++; $display("FAIL drop_gap: got %0d expected %0d", diff, GAP); end
      $display("drop: M dist %0d, idle %0d cycles after report", rep_q[1].d[1], diff);
    end
    repeat (400) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (trig_cnt[2] != 0) begin n_bad++; $display("FAIL drop_no_trig: got %0d L triggers expected 0", trig_cnt[2]); end
    n_cmp++; if (rep_q.size() != 2) begin n_bad++; $display("FAIL drop_no_rep: got %0d reports expected 2", rep_q.size()); end
  endtask

  task automatic test_reset_mid_trig();
    bit ok;
    int k;
    do_reset();
    randomize_sensors();
    bus.sens_mask = 3'b111;
    bus.enable = 1'b1;
    wait_reps(2, 4000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rtrig_wait: got %0d reports expected 2", rep_q.size()); end
    k = 0;
    while (bus.trig === 3'b000 && k < 2000) begin @(negedge clk); k++; end
    n_cmp++; if (bus.trig === 3'b000) begin n_bad++; $display("FAIL rtrig_no_trig: got %b expected nonzero", bus.trig); end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.trig !== 3'b000) begin n_bad++; $display("FAIL rtrig_trig: got %b expected 000", bus.trig); end
    n_cmp++;
    if ({bus.dist_r, bus.dist_m, bus.dist_l} !== 60'd0) begin
      n_bad++;
      $display("FAIL rtrig_dist: got r=%0d m=%0d l=%0d expected 0", bus.dist_r, bus.dist_m, bus.dist_l);
    end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rtrig_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    trig_order.delete();
    rst = 1'b0;
    k = 0;
    while (trig_order.size() == 0 && k < 200) begin @(negedge clk); k++; end
    n_cmp++;
    if (trig_order.size() == 0) begin n_bad++; $display("FAIL rtrig_restart: got no trigger expected R"); end
    else if (trig_order[0] != SENS_R) begin n_bad++; $display("FAIL rtrig_restart: got sensor %0d expected 0", trig_order[0]); end
    bus.enable = 1'b0;
    $display("reset mid-trigger: restart after %0d cycles", k);
  endtask

  task automatic test_random_masks();
    bit ok;
    int exp, prev, diff;
    logic [2:0] m, oh;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      randomize_sensors();
      m = 3'($urandom_range(7, 1));
      bus.sens_mask = m;
      bus.enable = 1'b1;
      wait_reps(3, 5000, ok);
      bus.enable = 1'b0;
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_wait[%0d]: got %0d reports expected 3", it, rep_q.size()); end
      prev = -1;
      for (int i = 0; i < rep_q.size() && i < 3; i++) begin
        exp = next_sens(prev, m);
        oh = 3'b001 << exp;
        diff = int'(rep_q[i].d[exp]) - wid[exp];
        n_cmp++; if (rep_q[i].done !== oh) begin n_bad++; $display("FAIL rnd_done[%0d.%0d]: got %b expected %b", it, i, rep_q[i].done, oh); end
        n_cmp++; if (diff < -2 || diff > 2) begin n_bad++; $display("FAIL rnd_dist[%0d.%0d]: got %0d expected %0d+/-2", it, i, rep_q[i].d[exp], wid[exp]); end
        $display("random: mask %b report %0d sensor %0d dist %0d", m, i, exp, rep_q[i].d[exp]);
        prev = exp;
      end
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.sens_mask = 3'b000;
    for (int s = 0; s < 3; s++) begin
      mode[s] = 0;
      dly[s] = 100;
      wid[s] = 500;
      trig_cnt[s] = 0;
      hl[s] = 0;
      tfall[s] = 0;
      rcnt[s] = 0;
      hcnt[s] = 0;
    end
    do_reset();
    test_reset();
    test_all_sensors();
    test_mask_101();
    test_timeout_m();
    test_saturation();
    test_stuck_l();
    test_enable_drop();
    test_reset_mid_trig();
    test_random_masks();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
